// File: rtl/scm_pkg.sv
// Shared types and constants for the scratch memory arbiter.
// Requester indices are stored in a fixed 3-bit field so NUM_REQ may range up to 8.
package scm_pkg;

  localparam int unsigned SCM_ADDR_W = 16;
  localparam int unsigned SCM_DATA_W = 16;

  localparam int unsigned HIST_BASE = 0;
  localparam int unsigned CDF_BASE  = 64;
  localparam int unsigned EQ_BASE   = 128;

  localparam int unsigned IDX_W = 3;
  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    lock_state_e lock;
    req_idx_t    owner;
    req_idx_t    rr_ptr;
  } arb_state_t;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } rd_tag_t;

  function automatic req_idx_t wrap_inc(input req_idx_t i, input req_idx_t last);
    return (i == last) ? '0 : req_idx_t'(i + 1'b1);
  endfunction

endpackage

// File: rtl/scm_rr_picker.sv
// Combinational round-robin selector: first eligible requester at or after rr_ptr_i,
// wrapping to index 0. Eligible means requested and not masked off.
module scm_rr_picker
  import scm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  req_idx_t           rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output req_idx_t           gnt_idx_o,
  output logic               gnt_any_o
);

  always_comb begin
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    gnt_o     = '0;
    // Descending loops leave the lowest match; the second pass overrides with
    // the lowest match at or above the pointer, so wrap-around is the fallback.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j] && mask_i[j]) begin
        gnt_idx_o = req_idx_t'(j);
        gnt_any_o = 1'b1;
      end
    end
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_i[j] && mask_i[j] && (req_idx_t'(j) >= rr_ptr_i)) begin
        gnt_idx_o = req_idx_t'(j);
        gnt_any_o = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      gnt_o[j] = gnt_any_o && (gnt_idx_o == req_idx_t'(j));
    end
  end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Round-robin arbiter sharing one single-port scratch memory between NUM_REQ requesters.
// Define SCM_ARB_LOCK_EN to let a requester hold the grant for a burst via req_lock.
module scratch_mem_arbiter
  import scm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = SCM_ADDR_W,
  parameter int unsigned DATA_W  = SCM_DATA_W,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy
);

  // Handshake: requester i holds req_valid and its fields stable until a cycle in
  // which req_valid[i] & req_gnt[i]; that cycle is the acceptance, and the next
  // cycle the access appears on the memory strobes.

  localparam req_idx_t LAST_IDX = req_idx_t'(NUM_REQ - 1);

  arb_state_t          st_q, st_d;
  rd_tag_t             tag_q [RD_LAT+1];
  logic [NUM_REQ-1:0]  lock_req;
  logic [NUM_REQ-1:0]  owner_oh;
  logic [NUM_REQ-1:0]  mask;
  logic [NUM_REQ-1:0]  gnt;
  req_idx_t            gnt_idx;
  logic                gnt_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                busy_d;

`ifdef SCM_ARB_LOCK_EN
  assign lock_req = req_lock;
`else
  logic lock_unused;
  assign lock_req    = '0;
  assign lock_unused = ^req_lock;
`endif

  always_comb begin
    owner_oh = '0;
    for (int j = 0; j < NUM_REQ; j++) owner_oh[j] = (st_q.owner == req_idx_t'(j));
    mask = (st_q.lock == LOCKED) ? owner_oh : '1;
  end

  scm_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i     (req_valid),
    .mask_i    (mask),
    .rr_ptr_i  (st_q.rr_ptr),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Lock FSM and round-robin pointer; a locked burst counts as a single turn.
  always_comb begin
    st_d = st_q;
    if (st_q.lock == LOCKED) begin
      if (((req_valid & owner_oh) == '0) || (gnt_any && ((lock_req & gnt) == '0))) begin
        st_d.lock   = UNLOCKED;
        st_d.rr_ptr = wrap_inc(st_q.owner, LAST_IDX);
      end
    end else if (gnt_any) begin
      if ((lock_req & gnt) != '0) begin
        st_d.lock  = LOCKED;
        st_d.owner = gnt_idx;
      end else begin
        st_d.rr_ptr = wrap_inc(gnt_idx, LAST_IDX);
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt[j]) begin
        sel_we    = req_we[j];
        sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= '{lock: UNLOCKED, owner: '0, rr_ptr: '0};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      st_q     <= st_d;
      mem_en_q <= gnt_any;
      mem_we_q <= gnt_any & sel_we;
      if (gnt_any) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      // Tag reaches the last stage in the cycle mem_rdata is valid for that read.
      tag_q[0] <= '{valid: gnt_any & ~sel_we, idx: gnt_idx};
      for (int k = 1; k <= RD_LAT; k++) tag_q[k] <= tag_q[k-1];
      for (int j = 0; j < NUM_REQ; j++) begin
        rsp_valid_q[j] <= tag_q[RD_LAT].valid && (tag_q[RD_LAT].idx == req_idx_t'(j));
      end
      if (tag_q[RD_LAT].valid) rsp_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    busy_d = (st_q.lock == LOCKED);
    for (int k = 0; k <= RD_LAT; k++) busy_d = busy_d | tag_q[k].valid;
  end

  assign req_gnt   = reset ? '0 : gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_d;

endmodule
